handshake_rx_fifo: RTL
======================

Name: handshake_rx_fifo

Overview:
- Read-domain consumer for the pulse/toggle CDC handshake.
- On each one-cycle read_it pulse, captures the mailbox word held stable by the write side and pushes it into a small FIFO.
- Presents the buffered words downstream as a valid/ready stream.
- Reports overflow when a pulse arrives with no room, plus a saturating drop count.

Parameters:
DATA_WIDTH, 8, width of mailbox word and stream data
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_WIDTH, 8, width of saturating drop counter

Ports:
clk  input  1  read-domain clock
rst_n  input  1  synchronous active-low reset
read_it  input  1  one-cycle capture pulse from handshake read side
data_in  input  DATA_WIDTH  mailbox word, stable while read_it is high
m_data  output  DATA_WIDTH  head-of-FIFO word
m_valid  output  1  m_data valid
m_ready  input  1  downstream accepts when m_valid & m_ready
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a pulse was dropped
drop_count  output  CNT_WIDTH  dropped pulses, saturates at all-ones
clear_err  input  1  synchronous clear of overflow and drop_count

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low. clk samples everything; rst_n is sampled only at posedge clk.
- Reset (rst_n=0 at posedge):
  - Pointers = 0, level = 0, m_valid = 0, m_data = 0, overflow = 0, drop_count = 0.
  - Storage contents need not be cleared.
  - Reset mid-operation discards all buffered words and error state. No drop is recorded for a read_it arriving in the reset cycle.
- Push = read_it & (level<DEPTH | pop). Pop = m_valid & m_ready.
  - Push writes data_in at the write pointer.
  - Pointers wrap modulo DEPTH, with an extra wrap bit for the full/empty distinction.
- Latency: word captured at edge N appears on m_data with m_valid=1 after edge N (registered, first-word fall-through). read_it to m_valid is 1 cycle.
- m_valid = (level != 0). m_data = storage[rd_ptr], updated the same cycle the pointer moves.
  - When empty, m_data holds the last head value (0 after reset). Bench must not check m_data while m_valid=0.
- Simultaneous push and pop:
  - level unchanged; both pointers advance.
  - Allowed when full, because pop frees the slot in the same cycle.
  - Allowed when level=1; the new word becomes head on the next cycle.
- Overflow: read_it=1 while level=DEPTH and no pop. Word discarded, storage unchanged, overflow set, drop_count incremented, saturating at 2^CNT_WIDTH-1.
- clear_err=1 clears overflow and drop_count next edge. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- m_valid is never deasserted without a pop. m_data is stable while m_valid & !m_ready.
- read_it held high for consecutive cycles is treated as consecutive pushes. The handshake never does this, but the block must not break.
- level is registered and updated on the same edge as the pointers.

Optional Feature:
- Macro: HANDSHAKE_RX_PARITY_EN.
- When defined:
  - Adds input parity_in (1), an even-parity bit accompanying data_in.
  - Adds output parity_err (1), sticky.
  - On push, if ^{data_in,parity_in} != 0: parity_err set; the word is still stored.
  - parity_err is cleared by clear_err with the same drop-wins rule (error wins). Reset value 0.
- When undefined: neither port exists; no parity logic.

Test Plan:
- Reset, then read_it pulse with data_in=8'hA5, m_ready=0 -> next cycle m_valid=1, m_data=A5, level=1; raise m_ready -> m_valid=0, level=0 next cycle.
- 4 pulses 01,02,03,04 with m_ready=0, then 5th pulse 05 -> level=4, overflow=1, drop_count=1. Drain gives 01,02,03,04 only.
- Full FIFO, read_it=1 with m_ready=1 in the same cycle, data 09 -> no overflow, level stays 4. Drain order: 02,03,04,09 (after 01 popped).
- 300 pulses while full and stalled -> drop_count=255 (saturated), overflow=1. clear_err -> both 0. clear_err coincident with a drop -> drop_count=1, overflow=1.
- rst_n=0 for one edge with level=3 and overflow=1 -> level=0, m_valid=0, overflow=0; next pulse with 7E is output correctly.
- With HANDSHAKE_RX_PARITY_EN: push 8'h03 with parity_in=1 -> parity_err=1, word still output; push 8'h03 with parity_in=0 -> no error.

Source files
------------

// File: rtl/handshake_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : handshake_rx_fifo
// Brief    : Read-domain consumer of the pulse/toggle CDC handshake. Each
//            read_it pulse captures the stable mailbox word into a small
//            first-word-fall-through FIFO drained as a valid/ready stream.
//            Pulses arriving with no room are dropped, flagged by a sticky
//            overflow bit and counted in a saturating drop counter.
//            Optional even-parity checking is compiled in when the macro
//            HANDSHAKE_RX_PARITY_EN is defined (adds parity_in/parity_err).
// Revision : 1.0 - initial release
// ============================================================================
module handshake_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       read_it,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic [DATA_WIDTH-1:0]      m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [CNT_WIDTH-1:0]       drop_count,
    input  logic                       clear_err
`ifdef HANDSHAKE_RX_PARITY_EN
    ,
    input  logic                       parity_in,
    output logic                       parity_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0]        c_full_level = LW'(DEPTH);
    localparam logic [AW:0]          c_ptr_one    = (AW+1)'(1);
    localparam logic [LW-1:0]        c_lvl_one    = LW'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max    = '1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one    = CNT_WIDTH'(1);

    // Storage is deliberately not reset; only the pointers define validity.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
    logic                   overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0]   drop_q, drop_d;

    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   full;

    // Push/pop decode, pointer and occupancy next-state, head-word lookahead
    always_comb begin
        full = (level_q == c_full_level);
        pop  = m_valid_q & m_ready;
        // A pop frees a slot in the same cycle, so a full FIFO still accepts.
        push = read_it & (~full | pop);
        drop = read_it & full & ~pop;

        wr_ptr_d = push ? (wr_ptr_q + c_ptr_one) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + c_ptr_one) : rd_ptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + c_lvl_one;
        end else if (pop && !push) begin
            level_d = level_q - c_lvl_one;
        end

        m_valid_d = (level_d != '0);

        // The head register tracks storage[rd_ptr]. When the word being
        // pushed this cycle lands exactly at the next head slot (empty FIFO,
        // or level 1 with a pop), forward it directly since storage is not
        // yet written. When the FIFO drains, keep the last head value.
        m_data_d = m_data_q;
        if (level_d != '0) begin
            if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
                m_data_d = data_in;
            end else begin
                m_data_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end

        // A drop in the same cycle as clear_err wins over the clear.
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_err) begin
                drop_d = c_cnt_one;
            end else if (drop_q != c_cnt_max) begin
                drop_d = drop_q + c_cnt_one;
            end
        end else if (clear_err) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end
    end

    // Write the captured mailbox word into storage on every accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_in;
        end
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

`ifdef HANDSHAKE_RX_PARITY_EN
    logic parity_err_q, parity_err_d;
    logic parity_bad;

    // Even parity over word plus parity bit; bad words are still stored
    always_comb begin
        parity_bad   = ^{data_in, parity_in};
        parity_err_d = parity_err_q;
        if (push && parity_bad) begin
            parity_err_d = 1'b1;
        end else if (clear_err) begin
            parity_err_d = 1'b0;
        end
    end

    // Sticky parity error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire
